// File: rtl/world_pkg.sv
// world_pkg: world geometry constants and collision FSM state type shared by the arbiter slice.
package world_pkg;
  localparam logic [10:0] WORLD_W = 11'd1280;
  localparam logic [7:0] WORLD_H = 8'd240;
  localparam int ADDR_W = 19;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} col_state_t;
endpackage

// File: rtl/world_rom_arbiter_if.sv
// world_rom_arbiter_if: collision lookup request/acknowledge bundle between a requester and the arbiter.
interface world_rom_arbiter_if;
  logic col_req;
  logic [10:0] col_x;
  logic [7:0] col_y;
  logic col_ack;
  logic [3:0] col_q;
  logic col_oob;
  modport master (output col_req, col_x, col_y, input col_ack, col_q, col_oob);
  modport slave (input col_req, col_x, col_y, output col_ack, col_q, col_oob);
endinterface

// File: rtl/world_addr_calc.sv
// world_addr_calc: maps world (x,y) to a linear ROM address y*1280+x using shifts instead of a multiplier.
module world_addr_calc
  import world_pkg::*;
(
  input  logic [10:0] x,
  input  logic [7:0] y,
  output logic [ADDR_W-1:0] addr
);
  assign addr = (ADDR_W'(y) << 10) + (ADDR_W'(y) << 8) + ADDR_W'(x);
endmodule

// File: rtl/world_rom_arbiter.sv
// world_rom_arbiter: shares one world ROM between the scrolled pixel path and a collision lookup FSM.
module world_rom_arbiter
  import world_pkg::*;
(
  input  logic vga_clk,
  input  logic Reset,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  input  logic blank,
  input  logic [10:0] scroll_x,
  world_rom_arbiter_if.slave col,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [3:0] rom_q,
  output logic [3:0] pix_index,
  output logic pix_valid
);
  col_state_t state;
  logic [10:0] scroll_q, sx_sum, wx;
  logic [ADDR_W-1:0] pix_addr, col_addr;
  logic blank_d, oob, col_drive, unused_lsb;
  assign unused_lsb = ^{DrawX[0], DrawY[9], DrawY[0]};
  // Half-resolution display: two screen pixels per world texel in each axis.
  assign sx_sum = 11'(DrawX[9:1]) + scroll_q;
  assign wx = sx_sum >= WORLD_W ? sx_sum - WORLD_W : sx_sum;
  assign oob = col.col_x >= WORLD_W || col.col_y >= WORLD_H;
  assign col_drive = state == ISSUE || (state == IDLE && col.col_req && !oob);
  world_addr_calc u_pix_calc (.x(wx), .y(DrawY[8:1]), .addr(pix_addr));
  world_addr_calc u_col_calc (.x(col.col_x), .y(col.col_y), .addr(col_addr));
  always_ff @(posedge vga_clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
      scroll_q <= '0;
      rom_address <= '0;
      pix_index <= '0;
      pix_valid <= 1'b0;
      blank_d <= 1'b0;
      col.col_ack <= 1'b0;
      col.col_q <= '0;
      col.col_oob <= 1'b0;
    end else begin
      if (DrawX == '0 && DrawY == '0)
        scroll_q <= scroll_x >= WORLD_W ? scroll_x - WORLD_W : scroll_x;
      blank_d <= blank;
      pix_valid <= blank_d;
      pix_index <= rom_q;
      col.col_ack <= 1'b0;
      // Active video always owns the ROM; collisions only steal blanking cycles.
      rom_address <= blank ? pix_addr : col_drive ? col_addr : rom_address;
      case (state)
        IDLE:
          if (col.col_req && oob) begin
            state <= DONE;
            col.col_ack <= 1'b1;
            col.col_oob <= 1'b1;
            col.col_q <= '0;
          end else if (col.col_req && !blank) state <= ISSUE;
        ISSUE: state <= blank ? IDLE : WAIT;
        WAIT: begin
          state <= DONE;
          col.col_ack <= 1'b1;
          col.col_oob <= 1'b0;
          col.col_q <= rom_q;
        end
        DONE: state <= IDLE;
      endcase
    end
  end
endmodule
